// File: rtl/lm80c_key_injector.sv
// Merges live PS/2 events with a queue of synthetic keystrokes, expanding each
// queued entry into a timed (SHIFT) press / hold / release / gap sequence.
module lm80c_key_injector #(
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 200000,
  parameter int GAP_CYCLES  = 200000,
  parameter int CW          = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kbd_valid,
  input  logic [15:0]                   kbd_key,
  input  logic                          kbd_status,
  input  logic                          inj_valid,
  input  logic [15:0]                   inj_key,
  input  logic                          inj_shift,
  output logic                          inj_ready,
  input  logic                          inj_abort,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          out_valid,
  output logic [15:0]                   out_key,
  output logic                          out_status
);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     PTR_ONE   = (AW+1)'(1);
  localparam logic [CW-1:0]   HOLD_L    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]   GAP_L     = CW'(GAP_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [15:0]     SHIFT_KEY = 16'h0012;

  // IDLE pop | SHIFT_DN/KEY_DN presses | HOLD wait | KEY_UP/SHIFT_UP releases | GAP wait
  typedef enum logic [2:0] {IDLE, SHIFT_DN, KEY_DN, HOLD, KEY_UP, SHIFT_UP, GAP} state_t;
  state_t state, state_nxt;

  logic [16:0]   mem [FIFO_DEPTH];
  logic [16:0]   mem_rd;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, push, pop;
  logic [15:0]   cur_key;
  logic          cur_shift;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          emit, emit_status;
  logic [15:0]   emit_key;

  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign inj_ready  = (fifo_level != DEPTH_L);
  assign push       = inj_valid & inj_ready & ~inj_abort;
  assign pop        = (state == IDLE) & ~empty & ~inj_abort;
  assign mem_rd     = mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE) | ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (inj_abort) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {inj_shift, inj_key};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_key   <= '0;
      cur_shift <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop) begin
        cur_key   <= mem_rd[15:0];
        cur_shift <= mem_rd[16];
      end
    end
  end

  // Emit states only complete when the live keyboard leaves the output free.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    emit        = 1'b0;
    emit_key    = cur_key;
    emit_status = 1'b1;
    case (state)
      IDLE: if (pop) state_nxt = mem_rd[16] ? SHIFT_DN : KEY_DN;
      SHIFT_DN: begin
        emit_key = SHIFT_KEY;
        if (inj_abort) state_nxt = IDLE;
        else if (!kbd_valid) begin
          emit      = 1'b1;
          state_nxt = KEY_DN;
        end
      end
      KEY_DN: begin
        if (inj_abort) state_nxt = cur_shift ? SHIFT_UP : IDLE;
        else if (!kbd_valid) begin
          emit      = 1'b1;
          cnt_nxt   = HOLD_L;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (inj_abort) state_nxt = KEY_UP;
        else begin
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nxt = KEY_UP;
        end
      end
      KEY_UP: begin
        emit_status = 1'b0;
        if (!kbd_valid) begin
          emit = 1'b1;
          if (cur_shift) state_nxt = SHIFT_UP;
          else begin
            cnt_nxt   = GAP_L;
            state_nxt = GAP;
          end
        end
      end
      SHIFT_UP: begin
        emit_key    = SHIFT_KEY;
        emit_status = 1'b0;
        if (!kbd_valid) begin
          emit      = 1'b1;
          cnt_nxt   = GAP_L;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (inj_abort) state_nxt = IDLE;
        else begin
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_key    <= '0;
      out_status <= 1'b0;
    end else begin
      out_valid <= kbd_valid | emit;
      if (kbd_valid) begin
        out_key    <= kbd_key;
        out_status <= kbd_status;
      end else if (emit) begin
        out_key    <= emit_key;
        out_status <= emit_status;
      end
    end
  end

endmodule

// File: tb/tb_lm80c_key_injector.sv
// Bench for lm80c_key_injector: directed scenarios and random traffic, compared
// every cycle against a model that expands each entry into an event script.
module tb_lm80c_key_injector;
  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;

  logic        clk = 1'b0, reset = 1'b1;
  logic        kbd_valid = 1'b0, kbd_status = 1'b0;
  logic [15:0] kbd_key = '0;
  logic        inj_valid = 1'b0, inj_shift = 1'b0, inj_abort = 1'b0;
  logic [15:0] inj_key = '0;
  logic        inj_ready, busy, out_valid, out_status;
  logic [4:0]  fifo_level;
  logic [15:0] out_key;

  int total = 0, bad = 0, cyc = 0, bsy_cnt = 0;

  typedef struct { int c; logic [15:0] k; logic s; } ev_t;
  ev_t ev[$];

  lm80c_key_injector #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .kbd_valid(kbd_valid), .kbd_key(kbd_key), .kbd_status(kbd_status),
    .inj_valid(inj_valid), .inj_key(inj_key), .inj_shift(inj_shift),
    .inj_ready(inj_ready), .inj_abort(inj_abort), .busy(busy), .fifo_level(fifo_level),
    .out_valid(out_valid), .out_key(out_key), .out_status(out_status));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of entries; the active entry is a script of emit/wait steps.
  logic [16:0] mq[$];
  bit          m_active = 0, m_shift = 0;
  int          m_step, m_left, m_n, m_hold, m_krel, m_srel;
  int          s_kind[6];
  logic [15:0] s_key[6];
  bit          s_st[6];
  int          s_len[6];
  logic        m_valid = 1'b0, m_status = 1'b0;
  logic [15:0] m_key = '0;

  task automatic set_step(int i, int kind, logic [15:0] k, bit st, int len);
    s_kind[i] = kind; s_key[i] = k; s_st[i] = st; s_len[i] = len;
  endtask

  task automatic enter(int st);
    m_step = st;
    if (st >= m_n) m_active = 0;
    else m_left = s_len[st];
  endtask

  task automatic load_script(logic [16:0] e);
    m_shift  = e[16];
    m_active = 1;
    if (e[16]) begin
      set_step(0, 0, 16'h12, 1, 0);   set_step(1, 0, e[15:0], 1, 0);
      set_step(2, 1, 0, 0, HOLD);     set_step(3, 0, e[15:0], 0, 0);
      set_step(4, 0, 16'h12, 0, 0);   set_step(5, 1, 0, 0, GAP);
      m_n = 6; m_hold = 2; m_krel = 3; m_srel = 4;
    end else begin
      set_step(0, 0, e[15:0], 1, 0);  set_step(1, 1, 0, 0, HOLD);
      set_step(2, 0, e[15:0], 0, 0);  set_step(3, 1, 0, 0, GAP);
      m_n = 4; m_hold = 1; m_krel = 2; m_srel = -1;
    end
    enter(0);
  endtask

  always @(posedge clk or posedge reset) begin : model_p
    int pre;
    bit do_pop, do_push;
    logic [16:0] e;
    if (reset) begin
      mq.delete(); m_active = 0; m_valid = 0; m_key = '0; m_status = 0;
    end else begin
      pre     = mq.size();
      do_pop  = !m_active && !inj_abort && pre > 0;
      do_push = inj_valid && pre < DEPTH && !inj_abort;
      m_valid = 0;
      if (kbd_valid) begin m_valid = 1; m_key = kbd_key; m_status = kbd_status; end
      if (m_active) begin
        if (inj_abort && !(s_kind[m_step] == 0 && s_st[m_step] == 0)) begin
          if (m_step == m_n - 1)              m_active = 0;
          else if (m_step == m_hold)          enter(m_krel);
          else if (m_shift && m_step == 1)    enter(m_srel);
          else                                m_active = 0;
        end else if (s_kind[m_step] == 0) begin
          if (!kbd_valid) begin
            m_valid = 1; m_key = s_key[m_step]; m_status = s_st[m_step];
            enter(m_step + 1);
          end
        end else begin
          m_left--;
          if (m_left == 0) enter(m_step + 1);
        end
      end
      if (inj_abort) mq.delete();
      if (do_pop) begin e = mq.pop_front(); load_script(e); end
      if (do_push) mq.push_back({inj_shift, inj_key});
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy) bsy_cnt++;
    if (out_valid) ev.push_back('{cyc, out_key, out_status});
    check("out", {out_valid, out_key, out_status}, {m_valid, m_key, m_status});
    check("level", fifo_level, mq.size());
    check("ready", inj_ready, mq.size() < DEPTH);
    check("busy", busy, m_active || mq.size() != 0);
  end

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check("idle_wait", busy, 0);
  endtask

  task automatic push1(logic [15:0] k, logic sh, output int t0);
    @(negedge clk); inj_valid = 1; inj_key = k; inj_shift = sh;
    @(negedge clk); inj_valid = 0; t0 = cyc;
  endtask

  initial begin
    int t0;
    logic [15:0] pk[$];
    logic [15:0] exk[4];
    logic        exs[4];
    int          exd[3];

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_key", out_key, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", inj_ready, 1);
    reset = 0;
    repeat (2) @(negedge clk);

    // single unshifted entry
    ev.delete(); bsy_cnt = 0;
    push1(16'h1c, 0, t0);
    wait_idle(100);
    check("s1_nev", ev.size(), 2);
    if (ev.size() == 2) begin
      check("s1_lat", ev[0].c - t0, 2);
      check("s1_press", {ev[0].k, ev[0].s}, {16'h1c, 1'b1});
      check("s1_space", ev[1].c - ev[0].c, HOLD + 1);
      check("s1_rel", {ev[1].k, ev[1].s}, {16'h1c, 1'b0});
    end
    check("s1_period", bsy_cnt, 3 + HOLD + GAP);

    // shifted entry
    ev.delete();
    push1(16'h16, 1, t0);
    wait_idle(100);
    exk = '{16'h12, 16'h16, 16'h16, 16'h12};
    exs = '{1, 1, 0, 0};
    exd = '{1, HOLD + 1, 1};
    check("s2_nev", ev.size(), 4);
    if (ev.size() == 4) begin
      check("s2_lat", ev[0].c - t0, 2);
      for (int i = 0; i < 4; i++) check("s2_ev", {ev[i].k, ev[i].s}, {exk[i], exs[i]});
      for (int i = 0; i < 3; i++) check("s2_gap", ev[i+1].c - ev[i].c, exd[i]);
    end

    // live contention on KEY_DN
    ev.delete();
    push1(16'h2a, 0, t0);
    @(negedge clk); kbd_valid = 1; kbd_key = 16'h29; kbd_status = 1;
    @(negedge clk); kbd_valid = 0;
    wait_idle(100);
    check("s3_nev", ev.size(), 3);
    if (ev.size() == 3) begin
      check("s3_live", {ev[0].c - t0, ev[0].k, ev[0].s}, {32'd2, 16'h29, 1'b1});
      check("s3_syn", {ev[1].c - t0, ev[1].k, ev[1].s}, {32'd3, 16'h2a, 1'b1});
    end

    // fill with the FSM stalled by live traffic, then drain in order
    ev.delete();
    kbd_key = 16'h55; kbd_status = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); kbd_valid = 1; inj_valid = 1; inj_key = 16'h100 + 16'(i); inj_shift = 0;
    end
    @(negedge clk); inj_valid = 0;
    check("s4_level", fifo_level, 16);
    check("s4_ready", inj_ready, 0);
    kbd_valid = 0;
    wait_idle(400);
    foreach (ev[i]) if (ev[i].s && ev[i].k >= 16'h100) pk.push_back(ev[i].k);
    check("s4_count", pk.size(), 17);
    foreach (pk[i]) check("s4_order", pk[i], 16'h100 + 16'(i));

    // abort in HOLD of a shifted entry with five more queued
    ev.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); inj_valid = 1; inj_key = (i == 0) ? 16'h33 : 16'h200 + 16'(i); inj_shift = (i == 0);
    end
    @(negedge clk); inj_valid = 0;
    check("s5_pre", fifo_level, 5);
    inj_abort = 1;
    @(negedge clk); inj_abort = 0;
    check("s5_flush", fifo_level, 0);
    wait_idle(50);
    exk = '{16'h12, 16'h33, 16'h33, 16'h12};
    check("s5_nev", ev.size(), 4);
    if (ev.size() == 4) begin
      for (int i = 0; i < 4; i++) check("s5_ev", {ev[i].k, ev[i].s}, {exk[i], exs[i]});
      check("s5_hold", ev[2].c - ev[1].c, 4);
    end

    // async reset during HOLD
    ev.delete();
    push1(16'h44, 0, t0);
    @(negedge clk); @(negedge clk);
    check("s6_pre", {out_valid, out_key}, {1'b1, 16'h44});
    #1 reset = 1;
    #1;
    check("s6_valid", out_valid, 0);
    check("s6_key", {out_key, out_status}, 0);
    check("s6_state", {fifo_level, busy, inj_ready}, {5'd0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    reset = 0; ev.delete();
    repeat (20) @(negedge clk);
    check("s6_norel", ev.size(), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      inj_valid  = ($urandom_range(0, 3) == 0);
      inj_key    = 16'($urandom_range(0, 16'hffff));
      inj_shift  = 1'($urandom_range(0, 1));
      kbd_valid  = ($urandom_range(0, 9) == 0);
      kbd_key    = 16'($urandom_range(0, 16'hffff));
      kbd_status = 1'($urandom_range(0, 1));
      inj_abort  = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    inj_valid = 0; kbd_valid = 0; inj_abort = 0;
    wait_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
